pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage ARM pipeline. It drives the freeze and flush inputs of the IF and ID stage registers and the global pipeline freeze.
- Sources: RAW hazards between the instruction in ID and in-flight writebacks in EXE/MEM, taken branches resolved in EXE, and multi-cycle SRAM accesses in MEM.
- Also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the pipeline stage registers and the hazard controller;
// master is the pipeline side, slave is the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic             exe_wb_en;
  logic [3:0]       exe_dest;
  logic             exe_mem_read;
  logic             mem_wb_en;
  logic [3:0]       mem_dest;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;

  logic             freeze_if;
  logic             flush_if;
  logic             flush_id;
  logic             freeze_pipe;
  logic             hazard;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, exe_wb_en, exe_dest, exe_mem_read,
           mem_wb_en, mem_dest, branch_taken, mem_req, sram_ready,
    input  freeze_if, flush_if, flush_id, freeze_pipe, hazard, mem_error, stall_cnt, state
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, exe_wb_en, exe_dest, exe_mem_read,
           mem_wb_en, mem_dest, branch_taken, mem_req, sram_ready,
    output freeze_if, flush_if, flush_id, freeze_pipe, hazard, mem_error, stall_cnt, state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: control outputs are same-cycle combinational,
// SRAM waits freeze the whole pipe. Define FORWARDING_EN to stall only on load-use hazards.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int                 WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [3:0]         FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } stateT;

  stateT             stateQ, stateD;
  logic [3:0]        flushCnt, flushD;
  logic [WAIT_W-1:0] waitCnt, waitD;
  logic              memErr;
  logic              errSet;
  logic [CNT_W-1:0]  stallCnt;
  logic              hazardRaw;
  logic              memStall;
  logic              freezeIf, flushIf, flushId, freezePipe;

`ifdef FORWARDING_EN
  // Ordinary RAW is forwarded; only a load in EXE feeding ID must wait.
  assign hazardRaw = bus.id_valid && bus.exe_wb_en && bus.exe_mem_read &&
                     ((bus.id_src1 == bus.exe_dest) ||
                      (bus.id_two_src && (bus.id_src2 == bus.exe_dest)));
`else
  logic src1Hit, src2Hit;
  assign src1Hit = (bus.exe_wb_en && (bus.id_src1 == bus.exe_dest)) ||
                   (bus.mem_wb_en && (bus.id_src1 == bus.mem_dest));
  assign src2Hit = (bus.exe_wb_en && (bus.id_src2 == bus.exe_dest)) ||
                   (bus.mem_wb_en && (bus.id_src2 == bus.mem_dest));
  assign hazardRaw = bus.id_valid && (src1Hit || (bus.id_two_src && src2Hit));
`endif

  assign memStall = bus.mem_req && !bus.sram_ready;

  always_comb begin
    stateD     = stateQ;
    flushD     = flushCnt;
    waitD      = waitCnt;
    errSet     = 1'b0;
    freezeIf   = 1'b0;
    flushIf    = 1'b0;
    flushId    = 1'b0;
    freezePipe = 1'b0;

    case (stateQ)
      // Branches and hazards are ignored here: the frozen EXE stage re-presents them.
      MEM_WAIT: begin
        if (bus.sram_ready) begin
          stateD = RUN;
          waitD  = '0;
        end else if (waitCnt == WAIT_MAX) begin
          errSet = 1'b1;
          stateD = RUN;
          waitD  = '0;
        end else begin
          freezePipe = 1'b1;
          waitD      = waitCnt + 1'b1;
        end
      end

      FLUSH: begin
        if (memStall) begin
          freezePipe = 1'b1;
          stateD     = MEM_WAIT;
          waitD      = WAIT_W'(1);
          flushD     = '0;
        end else begin
          flushIf = 1'b1;
          flushId = 1'b1;
          if (flushCnt < 4'd2) begin
            stateD = RUN;
            flushD = '0;
          end else begin
            flushD = flushCnt - 1'b1;
          end
        end
      end

      default: begin
        if (memStall) begin
          freezePipe = 1'b1;
          stateD     = MEM_WAIT;
          waitD      = WAIT_W'(1);
        end else if (bus.branch_taken) begin
          flushIf = 1'b1;
          flushId = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            stateD = FLUSH;
            flushD = FLUSH_INIT;
          end
        end else if (hazardRaw) begin
          freezeIf = 1'b1;
          flushId  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ   <= RUN;
      flushCnt <= '0;
      waitCnt  <= '0;
      memErr   <= 1'b0;
      stallCnt <= '0;
    end else begin
      stateQ   <= stateD;
      flushCnt <= flushD;
      waitCnt  <= waitD;
      if (errSet) begin
        memErr <= 1'b1;
      end
      if ((freezeIf || freezePipe) && (stallCnt != {CNT_W{1'b1}})) begin
        stallCnt <= stallCnt + 1'b1;
      end
    end
  end

  // Control outputs are forced low for the whole time reset is held.
  assign bus.freeze_if   = rst && freezeIf;
  assign bus.flush_if    = rst && flushIf;
  assign bus.flush_id    = rst && flushId;
  assign bus.freeze_pipe = rst && freezePipe;
  assign bus.hazard      = rst && hazardRaw;
  assign bus.mem_error   = memErr;
  assign bus.stall_cnt   = stallCnt;
  assign bus.state       = stateQ;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Drives two controller instances (different flush length, timeout and counter width) with shared
// stimulus and checks every output each cycle against a queue/counter based reference model.
module tb_pipeline_hazard_ctrl;

  localparam int FL_A = 2;
  localparam int TO_A = 8;
  localparam int CW_A = 16;
  localparam int FL_B = 3;
  localparam int TO_B = 3;
  localparam int CW_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW_A)) busA ();
  pipeline_hazard_ctrl_if #(.CNT_W(CW_B)) busB ();

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FL_A), .MEM_TIMEOUT(TO_A), .CNT_W(CW_A)) dutA (
    .clk(clk), .rst(rst), .bus(busA)
  );
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FL_B), .MEM_TIMEOUT(TO_B), .CNT_W(CW_B)) dutB (
    .clk(clk), .rst(rst), .bus(busB)
  );

  assign busB.id_valid     = busA.id_valid;
  assign busB.id_src1      = busA.id_src1;
  assign busB.id_src2      = busA.id_src2;
  assign busB.id_two_src   = busA.id_two_src;
  assign busB.exe_wb_en    = busA.exe_wb_en;
  assign busB.exe_dest     = busA.exe_dest;
  assign busB.exe_mem_read = busA.exe_mem_read;
  assign busB.mem_wb_en    = busA.mem_wb_en;
  assign busB.mem_dest     = busA.mem_dest;
  assign busB.branch_taken = busA.branch_taken;
  assign busB.mem_req      = busA.mem_req;
  assign busB.sram_ready   = busA.sram_ready;

  // Reference state per instance: outstanding SRAM wait, flush cycles still owed, sticky error, stalls.
  bit waiting[2];
  int waited[2];
  int flushOwed[2];
  bit err[2];
  int stalls[2];

  int nAssert = 0;
  int nFail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Any source operand of ID matching any in-flight producer that cannot be forwarded.
  function automatic bit refHazard();
    logic [3:0] producers[$];
    logic [3:0] sources[$];
    bit hit;
    hit = 1'b0;
    if (busA.id_valid !== 1'b1) return 1'b0;
    sources.push_back(busA.id_src1);
    if (busA.id_two_src) sources.push_back(busA.id_src2);
`ifdef FORWARDING_EN
    if (busA.exe_wb_en && busA.exe_mem_read) producers.push_back(busA.exe_dest);
`else
    if (busA.exe_wb_en) producers.push_back(busA.exe_dest);
    if (busA.mem_wb_en) producers.push_back(busA.mem_dest);
`endif
    foreach (sources[i]) foreach (producers[j]) if (sources[i] === producers[j]) hit = 1'b1;
    return hit;
  endfunction

  task automatic evalOne(input int k, input int fl, input int to, input int cmax,
                         input logic fi, input logic fli, input logic fld, input logic fp,
                         input logic hz, input logic me, input logic [31:0] sc, input logic [1:0] st);
    bit eFi, eFl, eFd, eFp, eHz;
    int eSt;
    string p;
    p   = (k == 0) ? "A" : "B";
    eFi = 0; eFl = 0; eFd = 0; eFp = 0;
    if (!rst) begin
      chk({p, ".rst.freeze_if"}, 32'(fi), 0);
      chk({p, ".rst.flush_if"}, 32'(fli), 0);
      chk({p, ".rst.flush_id"}, 32'(fld), 0);
      chk({p, ".rst.freeze_pipe"}, 32'(fp), 0);
      chk({p, ".rst.hazard"}, 32'(hz), 0);
      waiting[k] = 0; waited[k] = 0; flushOwed[k] = 0; err[k] = 0; stalls[k] = 0;
      return;
    end
    eSt = waiting[k] ? 1 : (flushOwed[k] > 0 ? 2 : 0);
    chk({p, ".state"}, 32'(st), 32'(eSt));
    chk({p, ".mem_error"}, 32'(me), 32'(err[k]));
    chk({p, ".stall_cnt"}, sc, 32'((stalls[k] > cmax) ? cmax : stalls[k]));
    eHz = refHazard();
    if (waiting[k]) begin
      if (busA.sram_ready) waiting[k] = 0;
      else if (waited[k] == to) begin waiting[k] = 0; err[k] = 1; end
      else begin eFp = 1; waited[k]++; end
    end else if (busA.mem_req && !busA.sram_ready) begin
      eFp = 1; waiting[k] = 1; waited[k] = 1; flushOwed[k] = 0;
    end else if (flushOwed[k] > 0) begin
      eFl = 1; eFd = 1; flushOwed[k]--;
    end else if (busA.branch_taken) begin
      eFl = 1; eFd = 1; flushOwed[k] = fl - 1;
    end else if (eHz) begin
      eFi = 1; eFd = 1;
    end
    if (eFi || eFp) stalls[k]++;
    chk({p, ".hazard"}, 32'(hz), 32'(eHz));
    chk({p, ".freeze_if"}, 32'(fi), 32'(eFi));
    chk({p, ".flush_if"}, 32'(fli), 32'(eFl));
    chk({p, ".flush_id"}, 32'(fld), 32'(eFd));
    chk({p, ".freeze_pipe"}, 32'(fp), 32'(eFp));
  endtask

  task automatic tick();
    @(negedge clk);
    evalOne(0, FL_A, TO_A, (1 << CW_A) - 1, busA.freeze_if, busA.flush_if, busA.flush_id,
            busA.freeze_pipe, busA.hazard, busA.mem_error, 32'(busA.stall_cnt), busA.state);
    evalOne(1, FL_B, TO_B, (1 << CW_B) - 1, busB.freeze_if, busB.flush_if, busB.flush_id,
            busB.freeze_pipe, busB.hazard, busB.mem_error, 32'(busB.stall_cnt), busB.state);
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    busA.id_valid = 0; busA.id_src1 = 0; busA.id_src2 = 0; busA.id_two_src = 0;
    busA.exe_wb_en = 0; busA.exe_dest = 0; busA.exe_mem_read = 0;
    busA.mem_wb_en = 0; busA.mem_dest = 0; busA.branch_taken = 0;
    busA.mem_req = 0; busA.sram_ready = 0;
  endtask

  task automatic setRaw(input logic [3:0] src, input logic [3:0] dst, input logic load);
    busA.id_valid = 1; busA.id_src1 = src; busA.exe_wb_en = 1; busA.exe_dest = dst;
    busA.exe_mem_read = load;
  endtask

  initial begin
    clearIn();
    rst = 0;
    repeat (2) tick();
    rst = 1;
    tick();

    // RAW from EXE, then load-use, then MEM-stage match on the second operand
    setRaw(4'd3, 4'd3, 1'b0); tick();
    clearIn(); tick();
    setRaw(4'd3, 4'd3, 1'b1); tick();
    clearIn();
    busA.id_valid = 1; busA.id_src1 = 4'd1; busA.id_src2 = 4'd5; busA.mem_wb_en = 1;
    busA.mem_dest = 4'd5; busA.id_two_src = 1; tick();
    busA.id_two_src = 0; tick();
    busA.id_src1 = 4'd13; busA.mem_dest = 4'd5; busA.exe_wb_en = 1; busA.exe_dest = 4'd12; tick();
    clearIn();

    // Taken branch while a hazard is present; flush wins and covers the configured length
    setRaw(4'd7, 4'd7, 1'b0); busA.branch_taken = 1; tick();
    busA.branch_taken = 0; repeat (4) tick();
    clearIn(); tick();

    // SRAM wait with a branch pulse mid-wait, then ready
    busA.mem_req = 1; busA.sram_ready = 0;
    repeat (2) tick();
    busA.branch_taken = 1; tick();
    busA.branch_taken = 0; repeat (2) tick();
    busA.sram_ready = 1; tick();
    clearIn(); tick();

    // Held-off SRAM: both instances time out and latch the error
    busA.mem_req = 1; busA.sram_ready = 0;
    repeat (10) tick();
    clearIn(); repeat (2) tick();

    // Long hazard run so the counters climb well past 37 (B saturates)
    setRaw(4'd9, 4'd9, 1'b1);
    repeat (40) tick();

    // Reset in the middle of an SRAM wait and in the middle of a flush
    clearIn(); busA.mem_req = 1; tick();
    rst = 0; repeat (2) tick();
    rst = 1; clearIn(); tick();
    busA.branch_taken = 1; tick();
    busA.branch_taken = 0; rst = 0; tick();
    rst = 1; tick();

    // Saturation after a clean reset: 20 stalled cycles
    setRaw(4'd2, 4'd2, 1'b1);
    repeat (20) tick();
    clearIn(); tick();

    // Randomized traffic with small register indices to provoke matches
    for (int n = 0; n < 600; n++) begin
      busA.id_valid     = 1'($urandom_range(0, 3) != 0);
      busA.id_src1      = 4'($urandom_range(0, 3));
      busA.id_src2      = 4'($urandom_range(0, 3));
      busA.id_two_src   = 1'($urandom);
      busA.exe_wb_en    = 1'($urandom);
      busA.exe_dest     = 4'($urandom_range(0, 3));
      busA.exe_mem_read = 1'($urandom);
      busA.mem_wb_en    = 1'($urandom);
      busA.mem_dest     = 4'($urandom_range(0, 3));
      busA.branch_taken = 1'($urandom_range(0, 7) == 0);
      busA.mem_req      = 1'($urandom_range(0, 4) == 0);
      busA.sram_ready   = 1'($urandom_range(0, 2) == 0);
      rst               = 1'($urandom_range(0, 99) != 0);
      tick();
    end
    rst = 1;
    clearIn();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
